regfile_mp_sb: RTL

- Parametrised successor to the RV32I integer register file.
- Configurable data width, register count and read-port count.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard so the decode stage can detect pending writebacks and stall without separate hazard logic.
- Sits between the decode stage (reads, issue marking) and the writeback stage (writes).

---
 rtl/regfile_mp_sb_if.sv | 34 +++
 rtl/regfile_mp_sb.sv | 92 +++++++++
 2 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the decode/writeback stages and the register file.
// Handshake: there is no valid/ready pair here. WE_reg and ISS_valid are
// single-cycle strobes that are always accepted on the rising edge. The
// decode stage applies back-pressure to itself by looking at RD_busy and
// any_busy, and stalls while an operand still has a pending writeback.
interface regfile_mp_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = $clog2(NREG)
);
   logic [NRD*AW-1:0]   RA;
   logic [NRD*XLEN-1:0] RD;
   logic [NRD-1:0]      RD_busy;
   logic                WE_reg;
   logic [AW-1:0]       WA;
   logic [XLEN-1:0]     WD_reg;
   logic                ISS_valid;
   logic [AW-1:0]       ISS_addr;
   logic                flush;
   logic                any_busy;

   // Pipeline side: drives reads, writebacks, issue marks and flush.
   modport master (
      output RA, WE_reg, WA, WD_reg, ISS_valid, ISS_addr, flush,
      input  RD, RD_busy, any_busy
   );

   // Register file side.
   modport slave (
      input  RA, WE_reg, WA, WD_reg, ISS_valid, ISS_addr, flush,
      output RD, RD_busy, any_busy
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with an optional write-to-read bypass and a
// per-register busy scoreboard. Reads are combinational. Writes, issue
// marks and flushes take effect on the rising edge.
module regfile_mp_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input logic            clk,
   input logic            rst,
   regfile_mp_sb_if.slave bus
);

   logic [XLEN-1:0]     mem_q [NREG];
   logic [XLEN-1:0]     mem_d [NREG];
   logic [NREG-1:0]     busy_q;
   logic [NREG-1:0]     busy_d;
   logic                wr_en;
   logic                iss_en;
   logic [NRD*XLEN-1:0] rd_mux;
   logic [NRD-1:0]      rd_busy_mux;
   logic [AW-1:0]       ra;

   // Register 0 swallows writes and issue marks when it is hardwired zero.
   always_comb begin
      wr_en  = bus.WE_reg    && !((ZERO_REG != 0) && (bus.WA == '0));
      iss_en = bus.ISS_valid && !((ZERO_REG != 0) && (bus.ISS_addr == '0));
   end

   // Next state. The order matters: flush clears everything, a writeback
   // then retires its own entry, and a new issue mark is applied last so it
   // wins over both (the new producer supersedes the completing one).
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (bus.flush) begin
         busy_d = '0;
      end
      if (wr_en) begin
         mem_d[bus.WA]  = bus.WD_reg;
         busy_d[bus.WA] = 1'b0;
      end
      if (iss_en) begin
         busy_d[bus.ISS_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // State registers. Reset overrides any write, issue or flush that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Read ports. A bypassed read sees the completing write, so it is never
   // busy; register 0 reads as zero and never busy when hardwired.
   always_comb begin
      rd_mux      = '0;
      rd_busy_mux = '0;
      ra          = '0;
      for (int k = 0; k < NRD; k++) begin
         ra                      = bus.RA[k*AW +: AW];
         rd_mux[k*XLEN +: XLEN]  = mem_q[ra];
         rd_busy_mux[k]          = busy_q[ra];
         if ((BYPASS != 0) && wr_en && (bus.WA == ra)) begin
            rd_mux[k*XLEN +: XLEN] = bus.WD_reg;
            rd_busy_mux[k]         = 1'b0;
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_mux[k*XLEN +: XLEN] = '0;
            rd_busy_mux[k]         = 1'b0;
         end
      end
   end

   assign bus.RD       = rd_mux;
   assign bus.RD_busy  = rd_busy_mux;
   assign bus.any_busy = |busy_q;

endmodule
